memory_bus_fabric: RTL and testbench

//  N-source successor to the single-slot request/response bus: a round-robin arbiter

---
 rtl/memory_bus_fabric.sv | 139 +++++++++++++
 tb/tb_memory_bus_fabric.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/memory_bus_fabric.sv
// N-source request/response fabric: a round-robin arbiter feeds a request FIFO toward one
// memory port, and responses return by source index through one-entry per-source slots.
module memory_bus_fabric #(
    parameter int N_SOURCES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int REQ_DEPTH = 4,
    localparam int PKT_W    = 2 + ID_W + ADDR_W + DATA_W,
    localparam int LVL_W    = $clog2(REQ_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_SOURCES-1:0]         src_req_valid,
    output logic [N_SOURCES-1:0]         src_req_ready,
    input  logic [N_SOURCES*PKT_W-1:0]   src_req_pkt,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [PKT_W-1:0]             mem_req_pkt,
    input  logic                         mem_rsp_valid,
    output logic                         mem_rsp_ready,
    input  logic [PKT_W-1:0]             mem_rsp_pkt,
    output logic [N_SOURCES-1:0]         src_rsp_valid,
    input  logic [N_SOURCES-1:0]         src_rsp_ready,
    output logic [N_SOURCES*PKT_W-1:0]   src_rsp_pkt,
    output logic [LVL_W-1:0]             req_level,
    output logic                         err_bad_id
);
    localparam int PTR_W   = $clog2(REQ_DEPTH);
    localparam int RR_W    = $clog2(N_SOURCES);
    localparam int SRC_LSB = ADDR_W + DATA_W;

    logic [PKT_W-1:0]     fifo_mem_q [REQ_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic [N_SOURCES-1:0] slot_valid_q, slot_valid_d;
    logic [PKT_W-1:0]     slot_pkt_q [N_SOURCES];
    logic [PKT_W-1:0]     slot_pkt_d [N_SOURCES];
    logic                 err_q, err_d;

    logic                 grant_found, push, pop;
    logic [RR_W-1:0]      grant_idx;
    logic [PKT_W-1:0]     push_pkt;
    logic [ID_W-1:0]      rsp_dest;
    logic                 rsp_bad, rsp_ready, rsp_accept;

    assign pop           = mem_req_valid && mem_req_ready;
    assign mem_req_valid = (level_q != '0);
    assign mem_req_pkt   = fifo_mem_q[rd_ptr_q];
    assign req_level     = level_q;
    assign err_bad_id    = err_q;

    // Round-robin scan from rr_q upward with wrap; first valid source wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_SOURCES; k++) begin
            int cand;
            cand = (int'(rr_q) + k) % N_SOURCES;
            if (!grant_found && src_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(cand);
            end
        end
    end

    // A full FIFO can still take a push when its head leaves in the same cycle.
    assign push          = grant_found && ((level_q < LVL_W'(REQ_DEPTH)) || pop);
    assign src_req_ready = push ? (N_SOURCES'(1) << grant_idx) : '0;

    always_comb begin
        push_pkt = src_req_pkt[grant_idx*PKT_W +: PKT_W];
        push_pkt[SRC_LSB +: ID_W] = ID_W'(grant_idx);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LVL_W'(1);
        if (pop && !push) level_d = level_q - LVL_W'(1);
        rr_d = rr_q;
        if (push) rr_d = (int'(grant_idx) == N_SOURCES - 1) ? '0 : grant_idx + RR_W'(1);
    end

    assign rsp_dest = mem_rsp_pkt[SRC_LSB +: ID_W];
    assign rsp_bad  = (int'(rsp_dest) >= N_SOURCES);

    // Only the addressed slot can block; bad-id responses are always swallowed.
    always_comb begin
        rsp_ready = rsp_bad;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (!rsp_bad && rsp_dest == ID_W'(i))
                rsp_ready = !slot_valid_q[i] || src_rsp_ready[i];
        end
    end

    assign mem_rsp_ready = rsp_ready;
    assign rsp_accept    = mem_rsp_valid && rsp_ready;

    always_comb begin
        for (int i = 0; i < N_SOURCES; i++) begin
            if (rsp_accept && !rsp_bad && rsp_dest == ID_W'(i)) begin
                slot_valid_d[i] = 1'b1;
                slot_pkt_d[i]   = mem_rsp_pkt;
            end else begin
                slot_valid_d[i] = slot_valid_q[i] && !src_rsp_ready[i];
                slot_pkt_d[i]   = slot_pkt_q[i];
            end
        end
        err_d = err_q || (rsp_accept && rsp_bad);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_pkt;
        for (int i = 0; i < N_SOURCES; i++) slot_pkt_q[i] <= slot_pkt_d[i];
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            rr_q         <= '0;
            slot_valid_q <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            rr_q         <= rr_d;
            slot_valid_q <= slot_valid_d;
            err_q        <= err_d;
        end
    end

    assign src_rsp_valid = slot_valid_q;

    generate
        for (genvar gi = 0; gi < N_SOURCES; gi++) begin : g_rsp_out
            assign src_rsp_pkt[gi*PKT_W +: PKT_W] = slot_pkt_q[gi];
        end
    endgenerate
endmodule

// File: tb/tb_memory_bus_fabric.sv
// Randomized bench for memory_bus_fabric, checked each cycle against a queue-based model
// of the arbiter, request FIFO and per-source response slots.
module tb_memory_bus_fabric;
    localparam int N       = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int PKT_W   = 2 + ID_W + ADDR_W + DATA_W;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int SRC_LSB = ADDR_W + DATA_W;
    localparam int CYCLES  = 1600;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         src_req_valid, src_req_ready;
    logic [N*PKT_W-1:0]   src_req_pkt;
    logic                 mem_req_valid, mem_req_ready;
    logic [PKT_W-1:0]     mem_req_pkt;
    logic                 mem_rsp_valid, mem_rsp_ready;
    logic [PKT_W-1:0]     mem_rsp_pkt;
    logic [N-1:0]         src_rsp_valid, src_rsp_ready;
    logic [N*PKT_W-1:0]   src_rsp_pkt;
    logic [LVL_W-1:0]     req_level;
    logic                 err_bad_id;

    memory_bus_fabric #(.N_SOURCES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .ID_W(ID_W), .REQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .src_req_valid(src_req_valid), .src_req_ready(src_req_ready), .src_req_pkt(src_req_pkt),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_pkt(mem_req_pkt),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_pkt(mem_rsp_pkt),
        .src_rsp_valid(src_rsp_valid), .src_rsp_ready(src_rsp_ready), .src_rsp_pkt(src_rsp_pkt),
        .req_level(req_level), .err_bad_id(err_bad_id)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL cycle %0d %s: got %h expected %h", cyc, tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input int kind, input int src,
                                                 input logic [31:0] addr, input logic [31:0] data);
        logic [1:0]      k;
        logic [ID_W-1:0] s;
        k = 2'(kind);
        s = ID_W'(src);
        return {k, s, addr, data};
    endfunction

    // Reference model state
    logic [PKT_W-1:0] model_q[$];
    int               model_rr;
    bit               model_sv[N];
    logic [PKT_W-1:0] model_sp[N];
    bit               model_err;

    task automatic model_reset();
        model_q.delete();
        model_rr  = 0;
        model_err = 0;
        for (int i = 0; i < N; i++) model_sv[i] = 0;
    endtask

    initial begin
        int               mode, g, d;
        bit               pop, push, bad, rready, accept;
        logic [N-1:0]     exp_ready;
        logic [PKT_W-1:0] p;

        reset = 1'b1; src_req_valid = '0; src_req_pkt = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_pkt = '0; src_rsp_ready = '0;
        model_reset();

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            // 0: reset, 1: all sources/ready, 2: fill FIFO, 3: slot-1 stall, 4: random
            mode = (cyc < 3) ? 0 : (cyc < 40) ? 1 : (cyc < 80) ? 2 : (cyc < 160) ? 3 : 4;
            reset = (mode == 0) || (mode == 4 && $urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                src_req_pkt[i*PKT_W +: PKT_W] = mk_pkt($urandom_range(0, 1), $urandom_range(0, 15),
                                                       $urandom(), $urandom());
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(N, 15) : $urandom_range(0, N - 1);
            mem_rsp_pkt = mk_pkt(2, d, $urandom(), $urandom());
            case (mode)
                1: begin
                    src_req_valid = '1; mem_req_ready = 1'b1;
                    mem_rsp_valid = 1'b0; src_rsp_ready = '1;
                end
                2: begin
                    src_req_valid = 4'b1010;
                    mem_req_ready = (cyc >= 60) && $urandom_range(0, 1) == 1;
                    mem_rsp_valid = 1'b0; src_rsp_ready = '1;
                end
                3: begin
                    src_req_valid = 4'(src_req_valid ^ 4'($urandom()));
                    mem_req_ready = $urandom_range(0, 1) == 1;
                    mem_rsp_pkt   = mk_pkt(2, $urandom_range(0, 1), $urandom(), $urandom());
                    mem_rsp_valid = 1'b1;
                    src_rsp_ready = 4'($urandom()) & 4'b1101;
                    if (cyc >= 130) src_rsp_ready[1] = ($urandom_range(0, 3) == 0);
                end
                default: begin
                    src_req_valid = 4'($urandom());
                    mem_req_ready = $urandom_range(0, 2) != 0;
                    mem_rsp_valid = $urandom_range(0, 1) == 1;
                    src_rsp_ready = 4'($urandom());
                end
            endcase
            #1;

            // Expected combinational decisions from the model's view
            pop = (model_q.size() > 0) && mem_req_ready;
            g = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (model_rr + k) % N;
                if (g < 0 && src_req_valid[c]) g = c;
            end
            push = (g >= 0) && (model_q.size() < DEPTH || pop);
            exp_ready = push ? N'(1 << g) : '0;
            d = int'(mem_rsp_pkt[SRC_LSB +: ID_W]);
            bad = (d >= N);
            rready = bad || !model_sv[d] || src_rsp_ready[d];
            accept = mem_rsp_valid && rready;

            check("src_req_ready", 128'(src_req_ready), 128'(exp_ready));
            check("mem_rsp_ready", 128'(mem_rsp_ready), 128'(rready));
            check("req_level", 128'(req_level), 128'(model_q.size()));
            check("mem_req_valid", 128'(mem_req_valid), 128'(model_q.size() > 0));
            if (model_q.size() > 0) check("mem_req_pkt", 128'(mem_req_pkt), 128'(model_q[0]));
            for (int i = 0; i < N; i++) begin
                check($sformatf("src_rsp_valid[%0d]", i), 128'(src_rsp_valid[i]), 128'(model_sv[i]));
                if (model_sv[i])
                    check($sformatf("src_rsp_pkt[%0d]", i),
                          128'(src_rsp_pkt[i*PKT_W +: PKT_W]), 128'(model_sp[i]));
            end
            check("err_bad_id", 128'(err_bad_id), 128'(model_err));

            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (push) begin
                    p = src_req_pkt[g*PKT_W +: PKT_W];
                    p[SRC_LSB +: ID_W] = ID_W'(g);
                    model_q.push_back(p);
                    model_rr = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (accept && !bad && d == i) begin
                        model_sv[i] = 1;
                        model_sp[i] = mem_rsp_pkt;
                    end else if (model_sv[i] && src_rsp_ready[i]) begin
                        model_sv[i] = 0;
                    end
                end
                if (accept && bad) model_err = 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
